// File: rtl/sobel_row_feeder_if.sv
// Pixel-in / row-out bundle between a pixel source and sobel_row_feeder.
// Handshake semantics (both channels): a transfer happens at a rising edge
// where valid and ready are both high; the producer holds data stable while
// valid is high and ready is low, and ready may depend on state only.
interface sobel_row_feeder_if #(
    parameter int SIZE = 5
);
    logic [7:0]           pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 frame_sync;
    logic [SIZE-1:0][7:0] arr_out;
    logic                 row_valid;
    logic                 row_ready;
    logic                 row_first;
    logic                 row_last;

    // Pixel source / row consumer side
    modport master (
        output pix_in, pix_valid, frame_sync, row_ready,
        input  pix_ready, arr_out, row_valid, row_first, row_last
    );

    // Feeder side
    modport slave (
        input  pix_in, pix_valid, frame_sync, row_ready,
        output pix_ready, arr_out, row_valid, row_first, row_last
    );
endinterface

// File: rtl/sobel_row_feeder.sv
// Serial-to-parallel row assembler feeding the Sobel filter. A fill buffer
// collects SIZE pixels while the output register presents the previous row;
// a two-state FSM (FILL/HOLD) stalls the pixel stream when a completed row
// cannot be handed over yet. dbg_hold_o exposes the FSM state (1 = HOLD).
module sobel_row_feeder #(
    parameter int SIZE   = 5,
    parameter int HEIGHT = 5
) (
    input  logic               clk,
    input  logic               rst,
    sobel_row_feeder_if.slave  bus,
    output logic               dbg_hold_o
);
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        rcnt_q, rcnt_d;
    logic [SIZE-1:0][7:0] fill_q, fill_d;
    logic [SIZE-1:0][7:0] arr_q, arr_d;
    logic                 valid_q, valid_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;

    logic                 pix_ready;
    logic                 accept;
    logic                 out_free;
    logic                 load;
    logic [SIZE-1:0][7:0] load_row;

    // Handshake qualifiers; ready is held low throughout reset
    always_comb begin
        pix_ready = (state_q == ST_FILL) && !rst;
        accept    = bus.pix_valid && pix_ready;
        out_free  = !valid_q || bus.row_ready;
    end

    // Next-state: pixel fill, row hand-over, frame restart
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        rcnt_d   = rcnt_q;
        fill_d   = fill_q;
        arr_d    = arr_q;
        valid_d  = valid_q;
        first_d  = first_q;
        last_d   = last_q;
        load     = 1'b0;
        load_row = fill_q;

        // Consumption; a load below overrides it (replace-in-place)
        if (valid_q && bus.row_ready) begin
            valid_d = 1'b0;
        end

        if (bus.frame_sync) begin
            // Drop partial or held row; a pixel on this edge opens row 0
            state_d = ST_FILL;
            rcnt_d  = '0;
            col_d   = '0;
            if (accept) begin
                fill_d[0] = bus.pix_in;
                col_d     = CW'(1);
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (out_free) begin
                                // Bypass the last pixel straight into the output
                                load               = 1'b1;
                                load_row[SIZE-1]   = bus.pix_in;
                            end else begin
                                fill_d[SIZE-1] = bus.pix_in;
                                state_d        = ST_HOLD;
                            end
                        end else begin
                            fill_d[col_q] = bus.pix_in;
                            col_d         = col_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_free) begin
                        load    = 1'b1;
                        state_d = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end

        // Position flags travel with the row, taken from its assigned index
        if (load) begin
            arr_d   = load_row;
            valid_d = 1'b1;
            first_d = (rcnt_q == '0);
            last_d  = (rcnt_q == ROW_LAST);
            rcnt_d  = (rcnt_q == ROW_LAST) ? '0 : rcnt_q + 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            col_q   <= '0;
            rcnt_q  <= '0;
            fill_q  <= '0;
            arr_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rcnt_q  <= rcnt_d;
            fill_q  <= fill_d;
            arr_q   <= arr_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Drive interface outputs and the debug state view
    always_comb begin
        bus.pix_ready = pix_ready;
        bus.arr_out   = arr_q;
        bus.row_valid = valid_q;
        bus.row_first = first_q;
        bus.row_last  = last_q;
        dbg_hold_o    = (state_q == ST_HOLD);
    end
endmodule
